// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_pkg : shared frame geometry and FSM state type for spi_master   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package spi_pkg;

   localparam int SPI_FRAME_BITS = 40;
   localparam int SPI_ADDR_BITS  = 8;
   localparam int SPI_DATA_BITS  = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GAP   = 3'd5
   } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_master_if : request/response handshake plus SPI pins            |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface spi_master_if;
   import spi_pkg::*;

   logic                     Start;
   logic [SPI_ADDR_BITS-1:0] Addr;
   logic                     Busy;
   logic                     Done;
   logic [SPI_DATA_BITS-1:0] Data_Out;
   logic                     SPI_CLK;
   logic                     SPI_CS;
   logic                     SPI_MOSI;
   logic                     SPI_MISO;

   modport master (
      input  Start, Addr, SPI_MISO,
      output Busy, Done, Data_Out, SPI_CLK, SPI_CS, SPI_MOSI
   );

   modport slave (
      output Start, Addr, SPI_MISO,
      input  Busy, Done, Data_Out, SPI_CLK, SPI_CS, SPI_MOSI
   );

endinterface
`default_nettype wire

// File: rtl/spi_half_period_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_half_period_timer : reloadable HALF_PERIOD down-counter         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module spi_half_period_timer #(
   parameter int HALF_PERIOD = 8
) (
   input  logic Clk,
   input  logic Reset,
   input  logic load_i,
   output logic expire_o
);

   localparam logic [7:0] C_RELOAD = 8'(HALF_PERIOD - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Loading HALF_PERIOD-1 makes expiry fall on the last cycle of the state.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = C_RELOAD;
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == 8'd0);

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_master : 40-bit read frame (8-bit address out, 32-bit data in)  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module spi_master
   import spi_pkg::*;
#(
   parameter int HALF_PERIOD = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   spi_master_if.master bus
);

   localparam int               CNT_W        = $clog2(SPI_FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] C_LAST_BIT   = CNT_W'(SPI_FRAME_BITS);
   localparam logic [CNT_W-1:0] C_FIRST_DATA = CNT_W'(SPI_FRAME_BITS - SPI_DATA_BITS);

   spi_state_e               state_q, state_d;
   logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
   logic [SPI_ADDR_BITS-1:0] addr_sr_q, addr_sr_d;
   logic                     cs_q, cs_d;
   logic                     sclk_q, sclk_d;
   logic                     mosi_q, mosi_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     rise_q, rise_d;
   logic                     miso_meta_q, miso_sync_q;
   logic [SPI_DATA_BITS-1:0] rx_q;
   logic [SPI_DATA_BITS-1:0] data_out_q;
   logic                     tmr_load;
   logic                     tmr_expire;

   spi_half_period_timer #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_timer (
      .Clk      (Clk),
      .Reset    (Reset),
      .load_i   (tmr_load),
      .expire_o (tmr_expire)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      addr_sr_d = addr_sr_q;
      tmr_load  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.Start) begin
               state_d   = ST_SETUP;
               addr_sr_d = bus.Addr;
               bit_cnt_d = '0;
               tmr_load  = 1'b1;
            end
         end
         ST_SETUP: begin
            if (tmr_expire) begin
               state_d  = ST_HIGH;
               tmr_load = 1'b1;
            end
         end
         ST_HIGH: begin
            if (tmr_expire) begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               tmr_load  = 1'b1;
               if (bit_cnt_d == C_LAST_BIT) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d   = ST_LOW;
                  addr_sr_d = {addr_sr_q[SPI_ADDR_BITS-2:0], 1'b0};
               end
            end
         end
         ST_LOW: begin
            if (tmr_expire) begin
               state_d  = ST_HIGH;
               tmr_load = 1'b1;
            end
         end
         ST_HOLD: begin
            if (tmr_expire) begin
               state_d  = ST_GAP;
               tmr_load = 1'b1;
            end
         end
         ST_GAP: begin
            if (tmr_expire) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Pin values are decoded from the next state so they register glitch-free.
      cs_d   = !(state_d inside {ST_SETUP, ST_HIGH, ST_LOW, ST_HOLD});
      sclk_d = (state_d == ST_HIGH);
      mosi_d = (state_d inside {ST_SETUP, ST_HIGH, ST_LOW}) ? addr_sr_d[SPI_ADDR_BITS-1] : 1'b0;
      busy_d = (state_d != ST_IDLE);
      done_d = (state_q == ST_HOLD) && (state_d == ST_GAP);
      rise_d = (state_q != ST_HIGH) && (state_d == ST_HIGH);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         addr_sr_q   <= '0;
         cs_q        <= 1'b1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rise_q      <= 1'b0;
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
         rx_q        <= '0;
         data_out_q  <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         addr_sr_q   <= addr_sr_d;
         cs_q        <= cs_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rise_q      <= rise_d;
         miso_meta_q <= bus.SPI_MISO;
         miso_sync_q <= miso_meta_q;
         // rise_q marks the first SPI_CLK-high cycle; the first 8 edges are address time.
         if (rise_q && (bit_cnt_q >= C_FIRST_DATA)) begin
            rx_q <= {rx_q[SPI_DATA_BITS-2:0], miso_sync_q};
         end
         if (done_d) begin
            data_out_q <= rx_q;
         end
      end
   end

   assign bus.SPI_CS   = cs_q;
   assign bus.SPI_CLK  = sclk_q;
   assign bus.SPI_MOSI = mosi_q;
   assign bus.Busy     = busy_q;
   assign bus.Done     = done_q;
   assign bus.Data_Out = data_out_q;

endmodule
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 8, meaning Clk cycles per SPI_CLK half-period; legal range 6..255.
REQ-002 SHALL have port Clk  input  1  system clock (50 MHz).
REQ-003 SHALL have port Reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port Start  input  1  request a read transaction; sampled only in IDLE.
REQ-005 SHALL have port Addr  input  8  register address to read; captured when Start is accepted.
REQ-006 SHALL have port Busy  output  1  high while a transaction is in progress.
REQ-007 SHALL have port Done  output  1  one-cycle pulse when Data_Out is valid.
REQ-008 SHALL have port Data_Out  output  32  word read from the slave.
REQ-009 SHALL have port SPI_CLK  output  1  serial clock, idle low.
REQ-010 SHALL have port SPI_CS  output  1  chip select, active low, idle high.
REQ-011 SHALL have port SPI_MOSI  output  1  serial data to the slave, MSB first.
REQ-012 SHALL have port SPI_MISO  input  1  serial data from the slave, asynchronous.

Function
REQ-013 Frame SHALL be 40 SPI_CLK cycles under one CS-low window: bits 1-8 carry Addr[7:0] MSB first; bits 9-40 carry MOSI=0.
REQ-014 MOSI SHALL change only while SPI_CLK is low; the slave samples on SPI_CLK rising.
REQ-015 SPI_MISO SHALL pass through a 2-flop synchronizer; the synchronized value SHALL be sampled on the Clk cycle SPI_CLK goes high.
REQ-016 Samples at rising edges 9..40 SHALL form Data_Out[31:0], edge 9 -> bit 31, edge 40 -> bit 0; samples 1-8 are discarded.
REQ-017 FSM states SHALL be IDLE, SETUP, HIGH, LOW, HOLD, GAP; each non-IDLE state lasts exactly HALF_PERIOD cycles.
REQ-018 IDLE: CS=1, CLK=0, MOSI=0; Start=1 -> SETUP next cycle, Addr latched.
REQ-019 SETUP: CS=0, CLK=0, MOSI=Addr[7] -> HIGH.
REQ-020 HIGH: CLK=1, bit counter increments on exit; counter=40 -> HOLD, else -> LOW.
REQ-021 LOW: CLK=0, MOSI advances to the next bit on entry -> HIGH.
REQ-022 HOLD: CS=0, CLK=0, MOSI=0 -> GAP.
REQ-023 GAP: CS=1; Data_Out updated and Done=1 on the first GAP cycle only -> IDLE.
REQ-024 Data_Out SHALL hold its value until the next Done.
REQ-025 CS low duration SHALL be exactly 81*HALF_PERIOD cycles; Busy SHALL be high exactly 82*HALF_PERIOD cycles, rising the cycle after Start acceptance.
REQ-026 Start asserted while Busy=1 SHALL be ignored, not queued.
REQ-027 Start held high continuously SHALL launch back-to-back transactions separated by the full GAP and one IDLE cycle.
REQ-028 All SPI outputs, Busy and Done SHALL be registered; no glitches.

Reset
REQ-029 On Reset: state=IDLE, SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, Busy=0, Done=0, Data_Out=0, counters cleared.
REQ-030 Reset mid-transaction SHALL raise SPI_CS on the next Clk edge, abort with no Done, and leave Data_Out=0.

Structure
REQ-031 Package spi_pkg SHALL hold the FSM state typedef, SPI_FRAME_BITS=40, SPI_ADDR_BITS=8, SPI_DATA_BITS=32.
REQ-032 Sub-module spi_half_period_timer SHALL provide a reloadable HALF_PERIOD down-counter with an expiry strobe; all other logic stays in spi_master.

Verification
REQ-033 Addr=0x03, slave model returns 0xDEADBEEF -> MOSI carries 00000011 then 32 zeros; Data_Out=0xDEADBEEF; Done pulses once.
REQ-034 HALF_PERIOD=8 -> CS low for 648 cycles, Busy high for 656, 40 SPI_CLK rising edges, first edge 8 cycles after CS falls.
REQ-035 Start pulsed during Busy -> ignored; exactly one frame and one Done.
REQ-036 Start held high with Addr=0x00 then 0xFF -> two complete frames, CS high >= 8 cycles between them, two Done pulses.
REQ-037 Reset asserted at rising edge 20 -> CS=1 next cycle, no Done, Data_Out=0, next Start produces a correct frame.
REQ-038 Slave model returns 0x80000001 with MISO changing 3 cycles after SPI_CLK falls -> Data_Out=0x80000001.
